aes_rx: RTL and testbench

AES_RX -- requirements
Module: aes_rx

---
 rtl/aes_port_pkg.sv | 14 +
 rtl/aes_rx.sv | 128 ++++++++++++
 tb/tb_aes_rx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_port_pkg.sv
// Shared definitions for the byte-serial AES port (receive and transmit sides).
package aes_port_pkg;

  localparam int BYTE_W      = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = BYTE_W * BLOCK_BYTES;

  // Receiver/transmitter framing state: IDLE means no byte of a block seen yet.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } aes_state_e;

endpackage : aes_port_pkg

// File: rtl/aes_rx.sv
// aes_rx: assembles 16 bytes from the byte-serial AES port into a 128-bit block.
// A byte is signalled by any level change on shakehand. The first byte lands
// in data[127:120]. A completed block is held until popped with take.
// Optional feature: define AES_RX_TIMEOUT_EN to abort a partial block after
// TIMEOUT_CYCLES idle en-cycles (err_timeout pulses). Without it, a partial
// block waits forever.
module aes_rx
  import aes_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [BYTE_W-1:0]  rx,
  input  logic               shakehand,
  input  logic               take,
  output logic [BLOCK_W-1:0] data,
  output logic               full,
  output logic               overflow,
  output logic               err_timeout
);

  localparam int CNT_W = $clog2(BLOCK_BYTES);
  // Only bytes 0..14 are stored. The 16th byte goes straight from rx into the block.
  localparam int ASM_W = BLOCK_W - BYTE_W;

  aes_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sh_q;
  logic [ASM_W-1:0]   asm_q;
  logic [BLOCK_W-1:0] asm_d;
  logic [BLOCK_W-1:0] data_q;
  logic               full_q;
  logic               ovf_q;
  logic               byte_det;
  logic               last_byte;
  logic               take_ok;
  logic               abort;

  assign byte_det  = en && (shakehand != sh_q);
  assign asm_d     = {asm_q, rx};
  assign last_byte = byte_det && (state_q == RECV) && (cnt_q == CNT_W'(BLOCK_BYTES - 1));
  assign take_ok   = en && take && full_q;

`ifdef AES_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_q;
  logic            err_q;

  // This is the last idle cycle that is tolerated. The abort happens on it.
  assign abort = en && (state_q == RECV) && !byte_det &&
                 (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter for a partial block, and the one-cycle abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (en) begin
        if ((state_q != RECV) || byte_det || abort) begin
          idle_q <= '0;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  assign err_timeout = err_q;
`else
  // The timeout hardware is compiled out. TIMEOUT_CYCLES is still referenced,
  // so the parameter remains part of the interface.
  assign abort       = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign err_timeout = 1'b0;
`endif

  // Framing FSM, byte counter, strobe history and assembly shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= 1'b1;
      asm_q   <= '0;
    end else if (en) begin
      sh_q <= shakehand;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (byte_det) begin
        asm_q   <= asm_d[ASM_W-1:0];
        // The counter wraps to 0 on the 16th byte, which also returns the FSM to IDLE.
        cnt_q   <= cnt_q + 1'b1;
        state_q <= last_byte ? IDLE : RECV;
      end
    end
  end

  // Output holding register: load on completion, pop on take, flag dropped blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (take_ok) begin
        full_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      if (last_byte) begin
        if (!full_q || take_ok) begin
          data_q <= asm_d;
          full_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign data     = data_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule : aes_rx

// File: tb/tb_aes_rx.sv
// tb_aes_rx: self-checking bench for aes_rx. It uses a queue-based block model,
// a directed vector table, and hand sequences for the multi-cycle corners.
// The timeout scenario is compiled in when AES_RX_TIMEOUT_EN is defined.
module tb_aes_rx;

  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [7:0]   rx;
  logic         shakehand;
  logic         take;
  logic [127:0] data;
  logic         full;
  logic         overflow;
  logic         err_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0]   mq[$];
  logic         m_sh;
  logic [127:0] m_data;
  logic         m_full;
  logic         m_ovf;
  logic         m_err;
`ifdef AES_RX_TIMEOUT_EN
  int           m_idle;
`endif

  logic         cur_sh;

  typedef struct {
    logic         en;
    logic         sh;
    logic [7:0]   rx;
    logic         take;
    logic         exp_full;
    logic         exp_ovf;
    logic [127:0] exp_data;
  } vec_t;

  vec_t tbl[18];

  aes_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rx          (rx),
    .shakehand   (shakehand),
    .take        (take),
    .data        (data),
    .full        (full),
    .overflow    (overflow),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [7:0] base);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_sh   = 1'b1;
    m_data = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_err  = 1'b0;
`ifdef AES_RX_TIMEOUT_EN
    m_idle = 0;
`endif
  endtask

  // Apply one edge's inputs to the model: collect bytes, then form blocks of 16.
  task automatic model_update(input logic e, input logic s, input logic [7:0] r, input logic t);
    logic [127:0] blk;
    bit done;
    bit took;
    done  = 0;
    blk   = '0;
    m_err = 1'b0;
    if (e) begin
      if (s != m_sh) begin
        mq.push_back(r);
`ifdef AES_RX_TIMEOUT_EN
        m_idle = 0;
`endif
        if (mq.size() == 16) begin
          for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = mq[i];
          mq.delete();
          done = 1;
        end
      end else if (mq.size() != 0) begin
`ifdef AES_RX_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          mq.delete();
          m_idle = 0;
          m_err  = 1'b1;
        end
`endif
      end
      m_sh = s;
      took = t && m_full;
      if (took) begin
        m_full = 1'b0;
        m_ovf  = 1'b0;
      end
      if (done) begin
        if (!m_full) begin
          m_data = blk;
          m_full = 1'b1;
          $display("block %h loaded", blk);
        end else begin
          m_ovf = 1'b1;
          $display("block %h dropped", blk);
        end
      end
    end
  endtask

  // One clock: drive the inputs, update the model at the edge, then compare just after the edge.
  task automatic step(input logic e, input logic s, input logic [7:0] r, input logic t);
    en = e; shakehand = s; rx = r; take = t;
    @(posedge clk);
    model_update(e, s, r, t);
    #1;
    chk("data", data, m_data);
    chk("full", 128'(full), 128'(m_full));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("err_timeout", 128'(err_timeout), 128'(m_err));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic t);
    cur_sh = ~cur_sh;
    step(1'b1, cur_sh, b, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, cur_sh, 8'($urandom), 1'b0);
  endtask

  task automatic send_block(input logic [7:0] base, input logic take_last);
    for (int i = 0; i < 16; i++) send_byte(base + 8'(i), (i == 15) ? take_last : 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    shakehand = 1'b1; en = 1'b0; take = 1'b0;
    cur_sh = 1'b1;
    model_clear();
    #2;
    chk("rst_data", data, 128'h0);
    chk("rst_full", 128'(full), 128'h0);
    chk("rst_overflow", 128'(overflow), 128'h0);
    chk("rst_err_timeout", 128'(err_timeout), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset applied");
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rx = '0; shakehand = 1'b1; take = 1'b0; cur_sh = 1'b1;
    model_clear();

    // Directed table: bytes 00..0F with shakehand 0,1,0,1..., then a hold cycle and a pop.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{en: 1'b1, sh: 1'(i % 2), rx: 8'(i), take: 1'b0,
                 exp_full: (i == 15), exp_ovf: 1'b0,
                 exp_data: (i == 15) ? 128'h000102030405060708090a0b0c0d0e0f : 128'h0};
    end
    tbl[16] = '{en: 1'b1, sh: 1'b1, rx: 8'hAA, take: 1'b0, exp_full: 1'b1, exp_ovf: 1'b0,
                exp_data: 128'h000102030405060708090a0b0c0d0e0f};
    tbl[17] = '{en: 1'b1, sh: 1'b1, rx: 8'h55, take: 1'b1, exp_full: 1'b0, exp_ovf: 1'b0,
                exp_data: 128'h000102030405060708090a0b0c0d0e0f};

    #1;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, tbl[i].sh, tbl[i].rx, tbl[i].take);
      $display("row %0d rx=%h sh=%0d take=%0d full=%0d", i, tbl[i].rx, tbl[i].sh, tbl[i].take, full);
      chk("tbl_data", data, tbl[i].exp_data);
      chk("tbl_full", 128'(full), 128'(tbl[i].exp_full));
      chk("tbl_overflow", 128'(overflow), 128'(tbl[i].exp_ovf));
    end
    cur_sh = tbl[17].sh;

    // Two blocks back-to-back with no take: the first is kept and the second is dropped.
    send_block(8'h10, 1'b0);
    send_block(8'h20, 1'b0);
    chk("b2b_data", data, pat(8'h10));
    chk("b2b_full", 128'(full), 128'h1);
    chk("b2b_overflow", 128'(overflow), 128'h1);
    step(1'b1, cur_sh, 8'h00, 1'b1);
    chk("pop_full", 128'(full), 128'h0);
    chk("pop_overflow", 128'(overflow), 128'h0);

    // Completion and take on the same edge: the new block replaces the old one.
    send_block(8'h30, 1'b0);
    send_block(8'h38, 1'b1);
    chk("swap_data", data, pat(8'h38));
    chk("swap_full", 128'(full), 128'h1);
    chk("swap_overflow", 128'(overflow), 128'h0);
    step(1'b1, cur_sh, 8'h00, 1'b1);

    // Random en gaps mid-block. Junk toggles and takes during en-low cycles must be ignored.
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 1) == 1) step(1'b0, ~cur_sh, 8'($urandom), 1'($urandom));
      send_byte(8'(i), 1'b0);
    end
    chk("en_gap_data", data, 128'h000102030405060708090a0b0c0d0e0f);
    chk("en_gap_full", 128'(full), 128'h1);
    step(1'b1, cur_sh, 8'h00, 1'b1);

`ifdef AES_RX_TIMEOUT_EN
    // Abort a partial block after TO idle en-cycles, then assemble a clean block.
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    idle(TO - 1);
    chk("pre_timeout", 128'(err_timeout), 128'h0);
    idle(1);
    chk("timeout_pulse", 128'(err_timeout), 128'h1);
    idle(1);
    chk("timeout_end", 128'(err_timeout), 128'h0);
    send_block(8'h40, 1'b0);
    chk("after_timeout_data", data, pat(8'h40));
    chk("after_timeout_full", 128'(full), 128'h1);
`else
    // Without the timeout, a long idle gap must not break the block.
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0);
    idle(10);
    chk("no_timeout", 128'(err_timeout), 128'h0);
    for (int i = 5; i < 16; i++) send_byte(8'h50 + 8'(i), 1'b0);
    chk("gap_block_data", data, pat(8'h50));
    chk("gap_block_full", 128'(full), 128'h1);
`endif
    step(1'b1, cur_sh, 8'h00, 1'b1);

    // Reset after byte 7 discards the partial block. The next 16 toggles form a block.
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0);
    do_reset();
    send_block(8'h60, 1'b0);
    chk("post_reset_data", data, pat(8'h60));
    chk("post_reset_full", 128'(full), 128'h1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic e;
      logic s;
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 1) == 1) ? ~cur_sh : cur_sh;
      if (e) cur_sh = s;
      step(e, s, 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_aes_rx
